// File: rtl/hanoi_move_gen.sv
// -----------------------------------------------------------------------------
// hanoi_move_gen
//
// Move sequencer for a Towers of Hanoi peg-state block. After a start request
// in IDLE it emits the optimal 2^S-1 move sequence for an S-disk tower, one
// (fr, to) peg pair per accepted valid/ready transfer. It then pulses done for
// one cycle and returns to IDLE.
//
// Move k (1-based) is derived from the move counter alone:
//   fr = (k & (k-1)) mod 3
//   to = ((k | (k-1)) + 1) mod 3   (evaluated at S+1 bits so k=2^S-1 does not wrap)
// Odd S finishes the tower on peg 2 and even S finishes it on peg 1.
//
// Optional feature (macro HANOI_DST_PEG2_EN):
//   defined     : for even S, pegs 1 and 2 are swapped on fr and to, so every
//                 tower finishes on peg 2. Odd S is unaffected.
//   not defined : raw arithmetic as above.
//
// Parameters:
//   S        number of disks, 1..16. The move counter is S bits wide, which
//            holds the largest move index 2^S-1.
//
// Ports:
//   clk       in   1  clock, rising edge
//   rst       in   1  synchronous active-high reset
//   start     in   1  begin a new sequence (sampled in IDLE only)
//   rdy       in   1  consumer accepts the current move when rdy & vld
//   fr        out  2  source peg of the current move
//   to        out  2  destination peg of the current move
//   vld       out  1  fr/to hold a valid move
//   busy      out  1  high in RUN and DONE
//   done      out  1  one-cycle pulse after the last move is accepted
//   move_cnt  out  S  moves accepted in the current/last sequence
// -----------------------------------------------------------------------------
module hanoi_move_gen #(
  parameter int S = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         rdy,
  output logic [1:0]   fr,
  output logic [1:0]   to,
  output logic         vld,
  output logic         busy,
  output logic         done,
  output logic [S-1:0] move_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [S-1:0] K_FIRST = S'(1);
  localparam logic [S-1:0] K_LAST  = '1;
  localparam logic [S:0]   X_ONE   = (S+1)'(1);
  localparam logic [S:0]   X_THREE = (S+1)'(3);

`ifdef HANOI_DST_PEG2_EN
  localparam bit SWAP_12 = (S % 2 == 0);
`else
  localparam bit SWAP_12 = 1'b0;
`endif

  state_t       r_state;
  logic [S-1:0] r_k;

  // Exchanges pegs 1 and 2 when even towers are steered onto peg 2.
  function automatic logic [1:0] remap(input logic [1:0] p);
    if (SWAP_12 && p == 2'd1) return 2'd2;
    if (SWAP_12 && p == 2'd2) return 2'd1;
    return p;
  endfunction

  function automatic logic [1:0] peg_fr(input logic [S-1:0] kk);
    logic [S:0] kx;
    logic [S:0] r;
    kx = {1'b0, kk};
    r  = (kx & (kx - X_ONE)) % X_THREE;
    return remap(2'(r));
  endfunction

  function automatic logic [1:0] peg_to(input logic [S-1:0] kk);
    logic [S:0] kx;
    logic [S:0] r;
    // Extra top bit keeps (2^S-1 | 2^S-2) + 1 = 2^S from wrapping to 0.
    kx = {1'b0, kk};
    r  = ((kx | (kx - X_ONE)) + X_ONE) % X_THREE;
    return remap(2'(r));
  endfunction

  // fr/to are reloaded together with k, so they are pure registered state
  // with no combinational path from start or rdy.
  // NOTE: every assignment in this clocked block is non-blocking so all
  // registers update from the same pre-edge values; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      fr       <= 2'd0;
      to       <= 2'd0;
      vld      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      move_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state  <= RUN;
            r_k      <= K_FIRST;
            fr       <= peg_fr(K_FIRST);
            to       <= peg_to(K_FIRST);
            vld      <= 1'b1;
            busy     <= 1'b1;
            move_cnt <= '0;
          end
        end
        RUN: begin
          if (rdy) begin
            move_cnt <= move_cnt + S'(1);
            if (r_k == K_LAST) begin
              // fr/to keep the final move; only vld drops.
              r_state <= DONE;
              vld     <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_k <= r_k + S'(1);
              fr  <= peg_fr(r_k + S'(1));
              to  <= peg_to(r_k + S'(1));
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          vld     <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hanoi_move_gen.sv
// -----------------------------------------------------------------------------
// tb_hanoi_move_gen
//
// Directed bench for hanoi_move_gen. Three instances share clk, rst and rdy:
// S=3 (main scenarios), S=2 (peg-parity / optional swap) and S=1 (single
// move). Inputs change and outputs are sampled on the falling clock edge.
// A small peg model replays the S=3 moves to confirm the tower is legal and
// ends on peg 2.
// -----------------------------------------------------------------------------
module tb_hanoi_move_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       start3, start2, start1;

  logic [1:0] fr3, to3, fr2, to2, fr1, to1;
  logic       vld3, busy3, done3;
  logic       vld2, busy2, done2;
  logic       vld1, busy1, done1;
  logic [2:0] cnt3;
  logic [1:0] cnt2;
  logic [0:0] cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hanoi_move_gen #(.S(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .rdy(rdy),
    .fr(fr3), .to(to3), .vld(vld3), .busy(busy3), .done(done3),
    .move_cnt(cnt3)
  );

  hanoi_move_gen #(.S(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .rdy(rdy),
    .fr(fr2), .to(to2), .vld(vld2), .busy(busy2), .done(done2),
    .move_cnt(cnt2)
  );

  hanoi_move_gen #(.S(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .rdy(rdy),
    .fr(fr1), .to(to1), .vld(vld1), .busy(busy1), .done(done1),
    .move_cnt(cnt1)
  );

  // Hand-derived optimal S=3 sequence ending on peg 2.
  logic [1:0] exp_fr3 [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
  logic [1:0] exp_to3 [7] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2};

`ifdef HANOI_DST_PEG2_EN
  logic [1:0] exp_fr2 [3] = '{2'd0, 2'd0, 2'd1};
  logic [1:0] exp_to2 [3] = '{2'd1, 2'd2, 2'd2};
`else
  logic [1:0] exp_fr2 [3] = '{2'd0, 2'd0, 2'd2};
  logic [1:0] exp_to2 [3] = '{2'd2, 2'd1, 2'd1};
`endif

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; start3 = 1'b0; start2 = 1'b0; start1 = 1'b0;
    step(); step();
    total++;
    if ({vld3, busy3, done3, cnt3, fr3, to3} !== 10'd0) begin
      bad++;
      $display("FAIL reset_s3: got vld=%b busy=%b done=%b cnt=%0d fr=%0d to=%0d, expected all 0",
               vld3, busy3, done3, cnt3, fr3, to3);
    end
    total++;
    if ({vld2, busy2, done2, cnt2, fr2, to2} !== 9'd0 ||
        {vld1, busy1, done1, cnt1, fr1, to1} !== 8'd0) begin
      bad++;
      $display("FAIL reset_s2_s1: got s2=%b s1=%b, expected all 0",
               {vld2, busy2, done2, cnt2, fr2, to2}, {vld1, busy1, done1, cnt1, fr1, to1});
    end
    rst = 1'b0;
    step();
  endtask

  // Runs one full S=3 sequence. Optionally stalls for stall_cycles while move
  // index stall_move is presented, and optionally pokes start in RUN and DONE.
  task automatic run_seq3(input string name, input int stall_move,
                          input int stall_cycles, input bit poke);
    int peg_of [3];
    int d;
    for (int j = 0; j < 3; j++) peg_of[j] = 0;
    start3 = 1'b1; rdy = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (vld3 !== 1'b1 || busy3 !== 1'b1 || done3 !== 1'b0 ||
          fr3 !== exp_fr3[i] || to3 !== exp_to3[i] || cnt3 !== 3'(i)) begin
        bad++;
        $display("FAIL %s_move%0d: got vld=%b busy=%b done=%b fr=%0d to=%0d cnt=%0d, expected vld=1 busy=1 done=0 fr=%0d to=%0d cnt=%0d",
                 name, i, vld3, busy3, done3, fr3, to3, cnt3, exp_fr3[i], exp_to3[i], i);
      end
      // Peg model: smallest disk on the source must land on a peg with no smaller disk.
      d = -1;
      for (int j = 2; j >= 0; j--) if (peg_of[j] == int'(fr3)) d = j;
      total++;
      if (d < 0) begin
        bad++;
        $display("FAIL %s_peg_src%0d: got empty source peg %0d, expected a disk", name, i, fr3);
      end else begin
        for (int j = 0; j < d; j++)
          if (peg_of[j] == int'(to3)) begin
            bad++;
            $display("FAIL %s_peg_dst%0d: got disk %0d onto smaller disk %0d, expected legal move",
                     name, i, d, j);
          end
        peg_of[d] = int'(to3);
      end
      if (poke && i == 3) start3 = 1'b1;
      if (i == stall_move) begin
        for (int c = 0; c < stall_cycles; c++) begin
          rdy = 1'b0;
          step();
          start3 = 1'b0;
          total++;
          if (vld3 !== 1'b1 || fr3 !== exp_fr3[i] || to3 !== exp_to3[i] || cnt3 !== 3'(i)) begin
            bad++;
            $display("FAIL %s_stall%0d: got vld=%b fr=%0d to=%0d cnt=%0d, expected vld=1 fr=%0d to=%0d cnt=%0d",
                     name, c, vld3, fr3, to3, cnt3, exp_fr3[i], exp_to3[i], i);
          end
        end
        rdy = 1'b1;
      end
      step();
      start3 = 1'b0;
    end
    total++;
    if (vld3 !== 1'b0 || busy3 !== 1'b1 || done3 !== 1'b1 || cnt3 !== 3'd7) begin
      bad++;
      $display("FAIL %s_done: got vld=%b busy=%b done=%b cnt=%0d, expected vld=0 busy=1 done=1 cnt=7",
               name, vld3, busy3, done3, cnt3);
    end
    if (poke) start3 = 1'b1;
    step();
    start3 = 1'b0;
    total++;
    if (vld3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0 || cnt3 !== 3'd7) begin
      bad++;
      $display("FAIL %s_idle: got vld=%b busy=%b done=%b cnt=%0d, expected vld=0 busy=0 done=0 cnt=7",
               name, vld3, busy3, done3, cnt3);
    end
    step();
    total++;
    if (vld3 !== 1'b0 || done3 !== 1'b0 || cnt3 !== 3'd7) begin
      bad++;
      $display("FAIL %s_idle_hold: got vld=%b done=%b cnt=%0d, expected vld=0 done=0 cnt=7",
               name, vld3, done3, cnt3);
    end
    total++;
    if (peg_of[0] != 2 || peg_of[1] != 2 || peg_of[2] != 2) begin
      bad++;
      $display("FAIL %s_tower: got disks on pegs %0d/%0d/%0d, expected 2/2/2",
               name, peg_of[0], peg_of[1], peg_of[2]);
    end
  endtask

  task automatic test_full();
    run_seq3("full", -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_seq3("stall", 1, 3, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_seq3("ignore", -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    start3 = 1'b1; rdy = 1'b1;
    step();
    start3 = 1'b0;
    repeat (4) step();
    total++;
    if (cnt3 !== 3'd4 || fr3 !== exp_fr3[4] || to3 !== exp_to3[4]) begin
      bad++;
      $display("FAIL midrst_pre: got cnt=%0d fr=%0d to=%0d, expected cnt=4 fr=%0d to=%0d",
               cnt3, fr3, to3, exp_fr3[4], exp_to3[4]);
    end
    rst = 1'b1;
    step();
    total++;
    if (vld3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0 || cnt3 !== 3'd0) begin
      bad++;
      $display("FAIL midrst: got vld=%b busy=%b done=%b cnt=%0d, expected 0 0 0 0",
               vld3, busy3, done3, cnt3);
    end
    // rst and start together: reset must win.
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    rst = 1'b0;
    step();
    total++;
    if (vld3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
      bad++;
      $display("FAIL rst_start: got vld=%b busy=%b done=%b, expected 0 0 0", vld3, busy3, done3);
    end
    run_seq3("replay", -1, 0, 1'b0);
  endtask

  task automatic test_s2();
    start2 = 1'b1; rdy = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (vld2 !== 1'b1 || fr2 !== exp_fr2[i] || to2 !== exp_to2[i] || cnt2 !== 2'(i)) begin
        bad++;
        $display("FAIL s2_move%0d: got vld=%b fr=%0d to=%0d cnt=%0d, expected vld=1 fr=%0d to=%0d cnt=%0d",
                 i, vld2, fr2, to2, cnt2, exp_fr2[i], exp_to2[i], i);
      end
      step();
    end
    total++;
    if (vld2 !== 1'b0 || done2 !== 1'b1 || busy2 !== 1'b1 || cnt2 !== 2'd3) begin
      bad++;
      $display("FAIL s2_done: got vld=%b done=%b busy=%b cnt=%0d, expected 0 1 1 3",
               vld2, done2, busy2, cnt2);
    end
    step();
  endtask

  task automatic test_s1();
    start1 = 1'b1; rdy = 1'b1;
    step();
    start1 = 1'b0;
    total++;
    if (vld1 !== 1'b1 || fr1 !== 2'd0 || to1 !== 2'd2 || cnt1 !== 1'b0) begin
      bad++;
      $display("FAIL s1_move: got vld=%b fr=%0d to=%0d cnt=%0d, expected vld=1 fr=0 to=2 cnt=0",
               vld1, fr1, to1, cnt1);
    end
    step();
    total++;
    if (vld1 !== 1'b0 || done1 !== 1'b1 || cnt1 !== 1'b1) begin
      bad++;
      $display("FAIL s1_done: got vld=%b done=%b cnt=%0d, expected vld=0 done=1 cnt=1",
               vld1, done1, cnt1);
    end
    step();
    total++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL s1_idle: got done=%b busy=%b, expected 0 0", done1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_s2();
    test_s1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
